lsu_unit: RTL and testbench

LSU_UNIT -- requirements
Module: lsu_unit

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_queue.sv | 52 +++++
 rtl/lsu_unit.sv | 159 +++++++++++++++
 tb/tb_lsu_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: op size, FSM state, queue entry layout.
// Also holds the alignment rule used by the queue head and by the AGU bypass path.
package lsu_pkg;

  localparam int DEFAULT_QUEUE_DEPTH = 4;
  localparam int MAX_TAG_W           = 16;
  localparam int NUM_LANES           = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } lsu_state_t;

  // tag is sized for the widest supported TAG_W; lsu_unit uses the low TAG_W bits
  typedef struct packed {
    logic [31:0]          addr;
    logic                 is_store;
    mem_size_t            size;
    logic                 is_signed;
    logic [31:0]          data;
    logic [MAX_TAG_W-1:0] tag;
  } lsu_entry_t;

  localparam int ENTRY_W = $bits(lsu_entry_t);

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_queue.sv
// In-order request FIFO; head is the oldest entry, valid whenever !empty.
// A push while full is dropped, so a pop never frees a slot within the same cycle.
module lsu_queue
  import lsu_pkg::*;
#(
  parameter int DEPTH = DEFAULT_QUEUE_DEPTH,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push, do_pop;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: queues AGU ops, issues one memory op at a time in program order,
// aligns store lanes, extracts/extends load data and reports results or misalignment.
module lsu_unit
  import lsu_pkg::*;
#(
  parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
  parameter int TAG_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             agu_valid,
  output logic             agu_ready,
  input  logic [31:0]      agu_addr,
  input  logic             agu_is_store,
  input  logic [1:0]       agu_size,
  input  logic             agu_signed,
  input  logic [31:0]      agu_store_data,
  input  logic [TAG_W-1:0] agu_tag,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_req_addr,
  output logic             mem_req_we,
  output logic [3:0]       mem_req_be,
  output logic [31:0]      mem_req_wdata,
  input  logic             mem_resp_valid,
  input  logic [31:0]      mem_resp_rdata,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data,
  output logic             wb_exc,
  input  logic             wb_ready
);

  lsu_state_t                      state, state_nxt;
  lsu_entry_t                      in_entry, head;
  logic [ENTRY_W-1:0]              head_bits;
  logic                            push, pop, capture;
  logic                            q_full, q_empty;
  logic                            head_mis, in_mis;
  logic [NUM_LANES-1:0]            lane_be;
  logic [NUM_LANES-1:0][7:0]       lane_wdata;
  logic [31:0]                     shifted, ld_ext, ld_data;
  logic                            unused_bits;

  always_comb begin
    in_entry           = '0;
    in_entry.addr      = agu_addr;
    in_entry.is_store  = agu_is_store;
    in_entry.size      = mem_size_t'(agu_size);
    in_entry.is_signed = agu_signed;
    in_entry.data      = agu_store_data;
    in_entry.tag       = MAX_TAG_W'(agu_tag);
  end

  assign agu_ready = !q_full;
  assign push      = agu_valid && agu_ready;

  lsu_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_entry),
    .pop       (pop),
    .head_data (head_bits),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign head     = lsu_entry_t'(head_bits);
  assign head_mis = is_misaligned(head.size, head.addr[1:0]);
  assign in_mis   = is_misaligned(mem_size_t'(agu_size), agu_addr[1:0]);

  // An op pushed into an empty queue is dispatched on the same edge, so the
  // request (or exception writeback) is visible the cycle after acceptance.
  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    capture       = 1'b0;
    mem_req_valid = 1'b0;
    wb_valid      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!q_empty)  state_nxt = head_mis ? ST_WB : ST_REQ;
        else if (push) state_nxt = in_mis ? ST_WB : ST_REQ;
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          if (head.is_store) begin
            pop       = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          capture   = 1'b1;
          state_nxt = ST_WB;
        end
      end
      ST_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          pop       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ld_data <= '0;
    end else begin
      state <= state_nxt;
      if (capture) ld_data <= ld_ext;
    end
  end

  // Per-byte-lane enables and store data; only aligned ops ever reach memory.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    assign lane_be[i] = (head.size == SZ_BYTE) ? (head.addr[1:0] == LANE) :
                        (head.size == SZ_HALF) ? (head.addr[1] == LANE[1]) : 1'b1;
    assign lane_wdata[i] = (head.size == SZ_BYTE) ? head.data[7:0] :
                           (head.size == SZ_HALF) ? head.data[8*(i%2) +: 8] :
                                                    head.data[8*i +: 8];
  end

  assign mem_req_addr  = {head.addr[31:2], 2'b00};
  assign mem_req_we    = head.is_store;
  assign mem_req_be    = lane_be;
  assign mem_req_wdata = lane_wdata;

  assign shifted = mem_resp_rdata >> {head.addr[1:0], 3'b000};

  always_comb begin
    ld_ext = mem_resp_rdata;
    case (head.size)
      SZ_BYTE: ld_ext = {{24{head.is_signed & shifted[7]}},  shifted[7:0]};
      SZ_HALF: ld_ext = {{16{head.is_signed & shifted[15]}}, shifted[15:0]};
      default: ld_ext = mem_resp_rdata;
    endcase
  end

  assign wb_tag  = head.tag[TAG_W-1:0];
  assign wb_exc  = wb_valid && head_mis;
  assign wb_data = (wb_valid && !head_mis) ? ld_data : 32'h0;

  assign unused_bits = ^{shifted[31:16], head.tag};

endmodule

// File: tb/tb_lsu_unit.sv
// Scoreboard bench for lsu_unit: expected memory requests and writebacks are queued
// as ops are driven and compared in order as the DUT produces them.
module tb_lsu_unit;

  localparam int QD = 4;
  localparam int TW = 6;

  logic          clk = 0, rst = 1;
  logic          agu_valid = 0, agu_ready;
  logic [31:0]   agu_addr = 0;
  logic          agu_is_store = 0;
  logic [1:0]    agu_size = 0;
  logic          agu_signed = 0;
  logic [31:0]   agu_store_data = 0;
  logic [TW-1:0] agu_tag = 0;
  logic          mem_req_valid, mem_req_ready = 1;
  logic [31:0]   mem_req_addr, mem_req_wdata;
  logic          mem_req_we;
  logic [3:0]    mem_req_be;
  logic          mem_resp_valid = 0;
  logic [31:0]   mem_resp_rdata = 0;
  logic          wb_valid, wb_exc, wb_ready = 1;
  logic [TW-1:0] wb_tag;
  logic [31:0]   wb_data;

  always #5 clk = ~clk;

  lsu_unit #(.QUEUE_DEPTH(QD), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .agu_valid(agu_valid), .agu_ready(agu_ready), .agu_addr(agu_addr),
    .agu_is_store(agu_is_store), .agu_size(agu_size), .agu_signed(agu_signed),
    .agu_store_data(agu_store_data), .agu_tag(agu_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_be(mem_req_be),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .wb_data(wb_data), .wb_exc(wb_exc), .wb_ready(wb_ready)
  );

  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;
  typedef struct { logic [TW-1:0] tag; logic [31:0] data; logic exc; } wb_t;

  req_t exp_req[$];
  wb_t  exp_wb[$];
  int   n_checks = 0, n_errors = 0;
  int   cyc = 0, acc_cyc = 0, req_cyc = 0, wb_cyc = 0;
  bit   req_seen = 0;
  bit   hold = 0, rnd_rdy = 0, spur = 0, wb_hold = 0, rnd_wb = 0;
  int   resp_lat = 1;
  logic [31:0] memv [logic [31:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (memv.exists(a)) return memv[a];
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic bit misal(input logic [1:0] sz, input logic [1:0] lo);
    return (sz == 2'd3) || (sz == 2'd1 && lo[0]) || (sz == 2'd2 && lo != 2'd0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'd0:    return 4'b0001 << lo;
      2'd1:    return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] lo, input bit sg);
    logic [31:0] s;
    logic [15:0] h;
    s = w >> (8 * lo);
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    return sg ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
      2'd1:    return sg ? {{16{h[15]}}, h} : {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Presents one op and holds it until accepted; call just after a rising edge.
  task automatic drive(input logic [31:0] a, input bit st, input logic [1:0] sz, input bit sg,
                       input logic [31:0] d, input logic [TW-1:0] tg);
    bit ok;
    int g;
    ok = 0; g = 0;
    agu_valid = 1; agu_addr = a; agu_is_store = st; agu_size = sz;
    agu_signed = sg; agu_store_data = d; agu_tag = tg;
    while (!ok && g < 300) begin
      @(negedge clk);
      ok = agu_ready;
      if (ok) acc_cyc = cyc;
      @(posedge clk); #1;
      g++;
    end
    if (!ok) chk("agu_accept_timeout", 0, 1);
    agu_valid = 0;
  endtask

  task automatic send(input logic [31:0] a, input bit st, input logic [1:0] sz, input bit sg,
                      input logic [31:0] d, input logic [TW-1:0] tg);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (misal(sz, a[1:0])) exp_wb.push_back('{tg, 32'h0, 1'b1});
    else begin
      exp_req.push_back('{wa, st, exp_be(sz, a[1:0]), st ? exp_wdata(sz, d) : 32'h0});
      if (!st) exp_wb.push_back('{tg, exp_load(memval(wa), sz, a[1:0], sg), 1'b0});
    end
    drive(a, st, sz, sg, d, tg);
  endtask

  task automatic wait_idle(input string nm);
    int g;
    g = 0;
    while ((exp_req.size() != 0 || exp_wb.size() != 0) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) chk(nm, 0, 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory and writeback-consumer model: responds resp_lat cycles after a load handshake.
  initial begin
    int pcnt;
    logic [31:0] paddr;
    pcnt = 0; paddr = 0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready && !mem_req_we) begin
        pcnt  = resp_lat;
        paddr = mem_req_addr;
      end
      @(posedge clk); #1;
      mem_resp_valid = 0;
      mem_resp_rdata = $urandom;
      if (pcnt > 0) begin
        pcnt--;
        if (pcnt == 0) begin
          mem_resp_valid = 1;
          mem_resp_rdata = memval(paddr);
        end
      end else if (spur) mem_resp_valid = $urandom_range(0, 1) == 1;
      mem_req_ready = hold ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1);
      wb_ready      = wb_hold ? 1'b0 : (rnd_wb ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  // Output monitor: in-order scoreboard compare plus hold-while-stalled checks.
  initial begin
    req_t r, pr;
    wb_t  w, pw;
    bit   pstall, pwstall;
    pstall = 0; pwstall = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pstall = 0; pwstall = 0;
        continue;
      end
      if (pstall) begin
        chk("req_hold_valid", mem_req_valid, 1);
        chk("req_hold_addr", mem_req_addr, pr.addr);
        chk("req_hold_be", mem_req_be, pr.be);
        chk("req_hold_wdata", mem_req_wdata, pr.wdata);
      end
      pstall = mem_req_valid && !mem_req_ready;
      pr = '{mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata};
      if (mem_req_valid && mem_req_ready) begin
        req_seen = 1; req_cyc = cyc;
        if (exp_req.size() == 0) chk("req_unexpected", 1, 0);
        else begin
          r = exp_req.pop_front();
          chk("req_addr", mem_req_addr, r.addr);
          chk("req_we", mem_req_we, r.we);
          chk("req_be", mem_req_be, r.be);
          if (r.we) chk("req_wdata", mem_req_wdata, r.wdata);
        end
      end
      if (pwstall) begin
        chk("wb_hold_valid", wb_valid, 1);
        chk("wb_hold_data", wb_data, pw.data);
        chk("wb_hold_tag", wb_tag, pw.tag);
        chk("wb_hold_exc", wb_exc, pw.exc);
      end
      pwstall = wb_valid && !wb_ready;
      pw = '{wb_tag, wb_data, wb_exc};
      if (wb_valid && wb_ready) begin
        wb_cyc = cyc;
        if (exp_wb.size() == 0) chk("wb_unexpected", 1, 0);
        else begin
          w = exp_wb.pop_front();
          chk("wb_tag", wb_tag, w.tag);
          chk("wb_data", wb_data, w.data);
          chk("wb_exc", wb_exc, w.exc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    memv[32'h2000] = 32'h8001_1234;
    memv[32'h5000] = 32'hDEAD_BEEF;

    // reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_agu_ready", agu_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_exc", wb_exc, 0);
    chk("rst_wb_data", wb_data, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // directed: fixed expectations
    exp_req.push_back('{32'h1000, 1'b1, 4'b1000, 32'hABAB_ABAB});
    drive(32'h1003, 1, 2'd0, 0, 32'h0000_00AB, 6'd1);
    exp_req.push_back('{32'h2000, 1'b0, 4'b1100, 32'h0});
    exp_wb.push_back('{6'd5, 32'hFFFF_8001, 1'b0});
    drive(32'h2002, 0, 2'd1, 1, 32'h0, 6'd5);
    exp_wb.push_back('{6'd6, 32'h0, 1'b1});
    drive(32'h3001, 0, 2'd2, 0, 32'h0, 6'd6);
    exp_req.push_back('{32'h2000, 1'b0, 4'b0010, 32'h0});
    exp_wb.push_back('{6'd10, 32'h0000_0012, 1'b0});
    drive(32'h2001, 0, 2'd0, 1, 32'h0, 6'd10);
    exp_req.push_back('{32'h2000, 1'b0, 4'b1000, 32'h0});
    exp_wb.push_back('{6'd11, 32'hFFFF_FF80, 1'b0});
    drive(32'h2003, 0, 2'd0, 1, 32'h0, 6'd11);
    exp_req.push_back('{32'h2000, 1'b0, 4'b1100, 32'h0});
    exp_wb.push_back('{6'd12, 32'h0000_8001, 1'b0});
    drive(32'h2002, 0, 2'd1, 0, 32'h0, 6'd12);
    exp_req.push_back('{32'h4000, 1'b1, 4'b1100, 32'hBEEF_BEEF});
    drive(32'h4002, 1, 2'd1, 0, 32'h1234_BEEF, 6'd2);
    exp_wb.push_back('{6'd3, 32'h0, 1'b1});
    drive(32'h4001, 1, 2'd1, 0, 32'h5555_5555, 6'd3);
    exp_wb.push_back('{6'd4, 32'h0, 1'b1});
    drive(32'h4000, 0, 2'd3, 0, 32'h0, 6'd4);
    wait_idle("directed_drain");

    // latency of an aligned load with ready memory
    send(32'h7000, 0, 2'd2, 0, 32'h0, 6'd20);
    wait_idle("latency_drain");
    chk("lat_req", req_cyc - acc_cyc, 1);
    chk("lat_wb", wb_cyc - acc_cyc, 3);

    // queue fills while memory stalls; fifth op waits, order preserved
    hold = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(32'h8000 + 4 * i, 1, 2'd2, 0, 32'h100 + i, 6'(i));
    @(negedge clk);
    chk("full_agu_ready", agu_ready, 0);
    fork
      send(32'h8010, 0, 2'd2, 0, 32'h0, 6'd33);
      begin
        repeat (3) @(negedge clk);
        chk("full_still_blocked", agu_ready, 0);
        hold = 0;
      end
    join
    wait_idle("full_drain");

    // writeback stall holds outputs and blocks the next op
    wb_hold = 1;
    @(posedge clk); #1;
    send(32'h5000, 0, 2'd2, 0, 32'h0, 6'd7);
    send(32'h6000, 1, 2'd2, 0, 32'h1234_5678, 6'd8);
    g = 0;
    while (!wb_valid && g < 100) begin @(negedge clk); g++; end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("wbstall_valid", wb_valid, 1);
      chk("wbstall_data", wb_data, 32'hDEAD_BEEF);
      chk("wbstall_tag", wb_tag, 6'd7);
      chk("wbstall_noreq", mem_req_valid, 0);
    end
    wb_hold = 0;
    wait_idle("wbstall_drain");

    // random mix with stalls and stray responses
    rnd_rdy = 1; rnd_wb = 1; spur = 1;
    for (int i = 0; i < 40; i++) begin
      send(32'hA000 + $urandom_range(0, 255), $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom, 6'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    wait_idle("random_drain");
    rnd_rdy = 0; rnd_wb = 0; spur = 0;
    @(posedge clk); #1;

    // reset while waiting for a load response
    resp_lat = 4;
    req_seen = 0;
    send(32'h9000, 0, 2'd2, 1, 32'h0, 6'd9);
    g = 0;
    while (!req_seen && g < 100) begin @(negedge clk); g++; end
    chk("rst_wait_req_seen", req_seen, 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_req.delete();
    exp_wb.delete();
    @(negedge clk);
    chk("rstw_req_valid", mem_req_valid, 0);
    chk("rstw_wb_valid", wb_valid, 0);
    chk("rstw_agu_ready", agu_ready, 1);
    chk("rstw_wb_exc", wb_exc, 0);
    repeat (8) @(negedge clk);
    chk("rstw_quiet_wb", wb_valid, 0);
    resp_lat = 1;
    @(posedge clk); #1;
    send(32'h2000, 0, 2'd2, 0, 32'h0, 6'd13);
    wait_idle("post_reset_drain");

    chk("sb_req_empty", exp_req.size(), 0);
    chk("sb_wb_empty", exp_wb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
